uart2wifi_core_tx_arbiter: RTL and testbench

UART2WIFI_CORE_TX_ARBITER -- requirements
Module: uart2wifi_core_tx_arbiter

---
 rtl/uart2wifi_core_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart2wifi_core_tx_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart2wifi_core_tx_arbiter.sv
// Two-requester arbiter that owns the UART TX FIFO write port for one whole frame.
// Define UART2WIFI_ARB_FIXED_PRIO_EN for fixed priority (req0 first); round-robin otherwise.
module uart2wifi_core_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       fifo_full,
    output logic       fifo_wr,
    output logic [7:0] fifo_wdata,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] frame_cnt
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] STALL_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_served_q, last_served_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]    wdata_q, wdata_d;

    logic [1:0] pick;
    logic       xfer0, xfer1, xfer_last, granted_valid;

    // Handshake: a byte moves when reqN_valid && reqN_ready; ready only for the owner and never while the FIFO is full.
    always_comb begin
`ifdef UART2WIFI_ARB_FIXED_PRIO_EN
        pick = req0_valid ? 2'b01 : 2'b10;
`else
        if (req0_valid && req1_valid) pick = last_served_q ? 2'b01 : 2'b10;
        else                          pick = req0_valid ? 2'b01 : 2'b10;
`endif
    end

    assign granted_valid = grant_q[0] ? req0_valid : req1_valid;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_served_d = last_served_q;
        frame_cnt_d   = frame_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        wdata_d       = wdata_q;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        fifo_wr       = 1'b0;
        timeout_err   = 1'b0;
        xfer0         = 1'b0;
        xfer1         = 1'b0;
        xfer_last     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d     = pick;
                    state_d     = XFER;
                    stall_cnt_d = '0;
                end
            end
            XFER: begin
                req0_ready = grant_q[0] && !fifo_full;
                req1_ready = grant_q[1] && !fifo_full;
                xfer0      = req0_valid && req0_ready;
                xfer1      = req1_valid && req1_ready;
                xfer_last  = xfer0 ? req0_last : req1_last;
                if (xfer0 || xfer1) begin
                    fifo_wr     = 1'b1;
                    wdata_d     = xfer0 ? req0_data : req1_data;
                    stall_cnt_d = '0;
                    if (xfer_last) begin
                        state_d       = IDLE;
                        grant_d       = 2'b00;
                        frame_cnt_d   = frame_cnt_q + 8'd1;
                        last_served_d = xfer1;
                    end
                end else if (!granted_valid && !fifo_full) begin
                    // Only a silent owner counts as stalled; FIFO backpressure never does.
                    if (stall_cnt_q == STALL_MAX) begin
                        timeout_err   = 1'b1;
                        state_d       = IDLE;
                        grant_d       = 2'b00;
                        last_served_d = grant_q[1];
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= 2'b00;
            last_served_q <= 1'b1;
            frame_cnt_q   <= 8'd0;
            stall_cnt_q   <= '0;
            wdata_q       <= 8'h00;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_served_q <= last_served_d;
            frame_cnt_q   <= frame_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            wdata_q       <= wdata_d;
        end
    end

    // Write data is live on a transfer and holds the last written byte otherwise.
    assign fifo_wdata = wdata_d;
    assign grant      = grant_q;
    assign busy       = (state_q == XFER);
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_uart2wifi_core_tx_arbiter.sv
// Directed bench for uart2wifi_core_tx_arbiter: byte sources, FIFO-write scoreboard, final report.
module tb_uart2wifi_core_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_last = 1'b0, req1_last = 1'b0;
    logic       req0_ready, req1_ready;
    logic       fifo_full = 1'b0;
    logic       fifo_wr;
    logic [7:0] fifo_wdata;
    logic [1:0] grant;
    logic       busy, timeout_err;
    logic [7:0] frame_cnt;

    uart2wifi_core_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
        .grant(grant), .busy(busy), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
    );

    always #10 clk = ~clk;

    int pass_cnt = 0, chk_cnt = 0;
    logic [8:0] src0_q[$], src1_q[$];   // {last, data}
    logic [7:0] exp_q[$];
    int cyc = 0, act_cnt = 0, wr_cnt = 0, to_cnt = 0, to_cyc = 0, last_xfer_cyc = 0;
    bit gap_pending = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive();
        req0_valid = src0_q.size() > 0;
        req0_data  = req0_valid ? src0_q[0][7:0] : 8'h00;
        req0_last  = req0_valid ? src0_q[0][8] : 1'b0;
        req1_valid = src1_q.size() > 0;
        req1_data  = req1_valid ? src1_q[0][7:0] : 8'h00;
        req1_last  = req1_valid ? src1_q[0][8] : 1'b0;
    endtask

    // One clock: monitor at the falling edge, then drive new inputs just after the rising edge.
    task automatic cycle();
        logic x0, x1, lst;
        logic [7:0] e;
        @(negedge clk);
        if (gap_pending) check("idle_gap", busy, 1'b0);
        gap_pending = 0;
        if (busy || req0_valid || req1_valid) act_cnt++;
        check("ready_excl", req0_ready & req1_ready, 1'b0);
        check("full_no_wr", fifo_wr & fifo_full, 1'b0);
        x0 = req0_valid & req0_ready;
        x1 = req1_valid & req1_ready;
        if (x0 | x1) begin
            lst = x0 ? req0_last : req1_last;
            if (exp_q.size() == 0) check("extra_wr", fifo_wdata, 32'hFFFF);
            else begin
                e = exp_q.pop_front();
                check("wdata", fifo_wdata, e);
            end
            check("wr_strobe", fifo_wr, 1'b1);
            check("owner", grant, x0 ? 2'b01 : 2'b10);
            if (x0) void'(src0_q.pop_front());
            else    void'(src1_q.pop_front());
            last_xfer_cyc = cyc;
            gap_pending = lst;
        end
        if (fifo_wr) wr_cnt++;
        if (timeout_err) begin
            to_cnt++;
            to_cyc = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_until_idle(input int max, output int n);
        int a0 = act_cnt;
        int k;
        for (k = 0; k < max; k++) begin
            if (src0_q.size() == 0 && src1_q.size() == 0 && !busy) break;
            cycle();
        end
        if (k == max) check("idle_bound", 32'd0, 32'd1);
        n = act_cnt - a0;
    endtask

    task automatic do_reset(input bit chk);
        rst = 1'b1;
        fifo_full = 1'b0;
        src0_q.delete(); src1_q.delete(); exp_q.delete();
        drive();
        gap_pending = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (chk) begin
            check("rst_grant", grant, 2'b00);
            check("rst_busy", busy, 1'b0);
            check("rst_to", timeout_err, 1'b0);
            check("rst_wr", fifo_wr, 1'b0);
            check("rst_wdata", fifo_wdata, 8'h00);
            check("rst_fcnt", frame_cnt, 8'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w0, t0, k;

        // Single 3-byte frame from req0
        do_reset(1'b1);
        src0_q = '{{1'b0, 8'h41}, {1'b0, 8'h42}, {1'b1, 8'h43}};
        exp_q  = '{8'h41, 8'h42, 8'h43};
        drive();
        run_until_idle(50, n);
        check("s1_frame_cycles", n, 4);
        check("s1_fcnt", frame_cnt, 8'd1);
        check("s1_grant_idle", grant, 2'b00);
        check("s1_wdata_hold", fifo_wdata, 8'h43);
        check("s1_exp_empty", exp_q.size(), 0);

        // Both requesters contend with 2-byte frames
        do_reset(1'b0);
        src0_q = '{{1'b0, 8'h10}, {1'b1, 8'h11}, {1'b0, 8'h20}, {1'b1, 8'h21}};
        src1_q = '{{1'b0, 8'h30}, {1'b1, 8'h31}};
`ifdef UART2WIFI_ARB_FIXED_PRIO_EN
        exp_q  = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31};
`else
        exp_q  = '{8'h10, 8'h11, 8'h30, 8'h31, 8'h20, 8'h21};
`endif
        drive();
        run_until_idle(100, n);
        check("s2_fcnt", frame_cnt, 8'd3);
        check("s2_exp_empty", exp_q.size(), 0);

        // Long FIFO backpressure mid-frame
        do_reset(1'b0);
        src0_q = '{{1'b0, 8'h50}, {1'b0, 8'h51}, {1'b1, 8'h52}};
        exp_q  = '{8'h50, 8'h51, 8'h52};
        drive();
        for (k = 0; k < 20; k++) begin
            if (exp_q.size() == 2) break;
            cycle();
        end
        check("s3_first_byte", exp_q.size(), 2);
        fifo_full = 1'b1;
        w0 = wr_cnt; t0 = to_cnt;
        repeat (3000) cycle();
        check("s3_no_wr", wr_cnt - w0, 0);
        check("s3_no_to", to_cnt - t0, 0);
        check("s3_busy", busy, 1'b1);
        check("s3_grant", grant, 2'b01);
        fifo_full = 1'b0;
        run_until_idle(50, n);
        check("s3_fcnt", frame_cnt, 8'd1);
        check("s3_exp_empty", exp_q.size(), 0);

        // req1 stalls after one byte and times out
        t0 = to_cnt;
        src1_q = '{{1'b0, 8'h60}};
        exp_q  = '{8'h60};
        drive();
        run_until_idle(100, n);
        check("s4_to_pulses", to_cnt - t0, 1);
        check("s4_to_delay", to_cyc - last_xfer_cyc, 16);
        check("s4_grant", grant, 2'b00);
        check("s4_busy", busy, 1'b0);
        check("s4_fcnt", frame_cnt, 8'd1);

        // Reset during the 2nd byte of a 4-byte frame
        do_reset(1'b0);
        src0_q = '{{1'b1, 8'h65}};
        exp_q  = '{8'h65};
        drive();
        run_until_idle(20, n);
        check("s5_pre_fcnt", frame_cnt, 8'd1);
        src0_q = '{{1'b0, 8'h70}, {1'b0, 8'h71}, {1'b0, 8'h72}, {1'b1, 8'h73}};
        exp_q  = '{8'h70, 8'h71, 8'h72, 8'h73};
        drive();
        for (k = 0; k < 20; k++) begin
            if (exp_q.size() == 3) break;
            cycle();
        end
        check("s5_mid_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("s5_rst_grant", grant, 2'b00);
        check("s5_rst_busy", busy, 1'b0);
        check("s5_rst_wr", fifo_wr, 1'b0);
        check("s5_rst_wdata", fifo_wdata, 8'h00);
        check("s5_rst_fcnt", frame_cnt, 8'd0);
        check("s5_rst_to", timeout_err, 1'b0);
        check("s5_rst_ready", req0_ready, 1'b0);
        src0_q.delete(); exp_q.delete(); gap_pending = 0;
        drive();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        src0_q = '{{1'b1, 8'h80}};
        src1_q = '{{1'b1, 8'h90}};
        exp_q  = '{8'h80, 8'h90};
        drive();
        cycle();
        check("s5_first_grant", grant, 2'b01);
        run_until_idle(20, n);
        check("s5_fcnt", frame_cnt, 8'd2);

        // 256 single-byte frames wrap the frame counter
        do_reset(1'b0);
        for (int i = 0; i < 255; i++) begin
            src0_q.push_back({1'b1, 8'(i)});
            exp_q.push_back(8'(i));
        end
        drive();
        run_until_idle(2000, n);
        check("s6_cycles_255", n, 510);
        check("s6_fcnt_255", frame_cnt, 8'd255);
        src0_q = '{{1'b1, 8'hAA}};
        exp_q  = '{8'hAA};
        drive();
        run_until_idle(20, n);
        check("s6_cycles_1", n, 2);
        check("s6_fcnt_wrap", frame_cnt, 8'd0);
        check("s6_exp_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
